// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the turn/result indicator:
//   - active-low 7-segment codes (bit 6 = g ... bit 0 = a)
//   - modo and jogador encodings
//   - FSM state enum and a helper that tells which states blink
// ---------------------------------------------------------------------------
package display_pkg;

   // Active-low segment codes
   localparam logic [6:0] SEG_J       = 7'b1100001;
   localparam logic [6:0] SEG_1       = 7'b1111001;
   localparam logic [6:0] SEG_2       = 7'b0100100;
   localparam logic [6:0] SEG_E       = 7'b0000110;
   localparam logic [6:0] SEG_TRACO   = 7'b0111111;
   localparam logic [6:0] SEG_APAGADO = 7'b1111111;

   // modo encodings
   localparam logic [1:0] MODO_NORMAL  = 2'b00;
   localparam logic [1:0] MODO_VITORIA = 2'b01;
   localparam logic [1:0] MODO_EMPATE  = 2'b10;
   localparam logic [1:0] MODO_APAGADO = 2'b11;

   // jogador encodings
   localparam logic [1:0] JOG_NENHUM = 2'b00;
   localparam logic [1:0] JOG_1      = 2'b01;
   localparam logic [1:0] JOG_2      = 2'b10;
   localparam logic [1:0] JOG_ERRO   = 2'b11;

   typedef enum logic [2:0] {
      FIXO,
      DESTAQUE,
      VITORIA,
      EMPATE,
      APAGADO
   } estado_t;

   // States in which the blink timebase runs
   function automatic logic estado_pisca(input estado_t e);
      return (e == DESTAQUE) || (e == VITORIA) || (e == EMPATE);
   endfunction

endpackage

// File: rtl/display_vez_jogador_contador_pisca.sv
// ---------------------------------------------------------------------------
// contador_pisca
// Blink timebase. Counts 0..MEIO_PERIODO-1; at terminal count it wraps to 0
// and toggles fase.
//   clock   in   system clock
//   reset   in   synchronous, active-low reset (counter 0, fase 1)
//   clear   in   restart the timebase: counter 0, fase 1
//   hold    in   keep the timebase parked at counter 0, fase 1
//   fase    out  current blink phase, 1 = lit
//   expira  out  high during the single cycle the counter sits at terminal
//                count, i.e. the next edge is a half-period expiry
// ---------------------------------------------------------------------------
module contador_pisca #(
   parameter int MEIO_PERIODO = 25_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic hold,
   output logic fase,
   output logic expira
);

   localparam int LARG = $clog2(MEIO_PERIODO);
   localparam logic [LARG-1:0] TERMINAL = LARG'(MEIO_PERIODO - 1);

   logic [LARG-1:0] cont_reg;
   logic            fase_reg;

   always_ff @(posedge clock) begin
      if (!reset || clear || hold) begin
         cont_reg <= '0;
         fase_reg <= 1'b1;
      end else if (cont_reg == TERMINAL) begin
         cont_reg <= '0;
         fase_reg <= ~fase_reg;
      end else begin
         cont_reg <= cont_reg + 1'b1;
      end
   end

   assign fase   = fase_reg;
   // Since MEIO_PERIODO >= 2, a held/cleared counter (0) never flags expiry.
   assign expira = (cont_reg == TERMINAL);

endmodule

// File: rtl/display_vez_jogador.sv
// ---------------------------------------------------------------------------
// display_vez_jogador
// Registered two-digit turn/result indicator ("J1", "J2", "-E", "--") with
// result modes, configurable blink timebase and a short blinking highlight
// whenever the turn passes to a player.
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-low reset
//   jogador [1:0]  in   00 none, 01 player 1, 10 player 2, 11 error
//   modo    [1:0]  in   00 normal, 01 vitoria, 10 empate, 11 apagado
//   display_letra  out  left digit, active-low segments (bit 6 = g)
//   display_num    out  right digit, same encoding
//   fase           out  current blink phase, 1 = lit
// Parameters: MEIO_PERIODO (blink half-period in cycles, >= 2),
//             N_PISCAS (full blink periods per highlight, >= 1).
// Build option: define ALTERNANCIA_EN to make EMPATE alternate J/1 and J/2
// instead of blinking dash/dash.
// ---------------------------------------------------------------------------
module display_vez_jogador
   import display_pkg::*;
#(
   parameter int MEIO_PERIODO = 25_000_000,
   parameter int N_PISCAS     = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] jogador,
   input  logic [1:0] modo,
   output logic [6:0] display_letra,
   output logic [6:0] display_num,
   output logic       fase
);

   localparam int LARG_MEIOS = $clog2(2 * N_PISCAS);
   localparam logic [LARG_MEIOS-1:0] ULTIMO_MEIO = LARG_MEIOS'(2 * N_PISCAS - 1);

   estado_t               estado_reg, estado_next;
   logic [1:0]            jogador_ant_reg;
   logic [LARG_MEIOS-1:0] meios_reg, meios_next;
   logic [6:0]            letra_reg, letra_next;
   logic [6:0]            num_reg, num_next;
   logic [6:0]            letra_cont, num_cont;
   logic                  troca, reinicio;
   logic                  clear, hold, expira, fase_cont, fase_next;

   contador_pisca #(
      .MEIO_PERIODO (MEIO_PERIODO)
   ) u_contador (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear),
      .hold   (hold),
      .fase   (fase_cont),
      .expira (expira)
   );

   // A turn passes only when jogador moves to an actual player.
   assign troca = (jogador != jogador_ant_reg) &&
                  ((jogador == JOG_1) || (jogador == JOG_2));

   // Next state: modo overrides everything; normal mode chooses FIXO/DESTAQUE.
   always_comb begin
      estado_next = estado_reg;
      reinicio    = 1'b0;
      case (modo)
         MODO_VITORIA: estado_next = VITORIA;
         MODO_EMPATE:  estado_next = EMPATE;
         MODO_APAGADO: estado_next = APAGADO;
         default: begin
            case (estado_reg)
               FIXO: begin
                  if (troca) estado_next = DESTAQUE;
               end
               DESTAQUE: begin
                  if (troca) begin
                     reinicio = 1'b1;
                  end else if (expira && (meios_reg == ULTIMO_MEIO)) begin
                     estado_next = FIXO;
                  end
               end
               // Returning from a result mode never starts a highlight.
               default: estado_next = FIXO;
            endcase
         end
      endcase
   end

   // Timebase control and the phase that will be visible after this edge,
   // so the registered digits line up with the registered fase.
   always_comb begin
      clear     = estado_pisca(estado_next) && ((estado_next != estado_reg) || reinicio);
      hold      = !estado_pisca(estado_next);
      fase_next = fase_cont;
      if (clear || hold) begin
         fase_next = 1'b1;
      end else if (expira) begin
         fase_next = ~fase_cont;
      end
   end

   // Half-period expiries counted only while a highlight runs.
   always_comb begin
      meios_next = meios_reg;
      if ((estado_next != DESTAQUE) || clear) begin
         meios_next = '0;
      end else if (expira) begin
         meios_next = meios_reg + 1'b1;
      end
   end

   // Digit content before blanking.
   always_comb begin
      letra_cont = SEG_TRACO;
      num_cont   = SEG_TRACO;
      case (jogador)
         JOG_1: begin
            letra_cont = SEG_J;
            num_cont   = SEG_1;
         end
         JOG_2: begin
            letra_cont = SEG_J;
            num_cont   = SEG_2;
         end
         JOG_ERRO: num_cont = SEG_E;
         default: ;
      endcase
   end

   // Segment mux with blanking.
   always_comb begin
      letra_next = SEG_APAGADO;
      num_next   = SEG_APAGADO;
      case (estado_next)
         FIXO: begin
            letra_next = letra_cont;
            num_next   = num_cont;
         end
         DESTAQUE, VITORIA: begin
            if (fase_next) begin
               letra_next = letra_cont;
               num_next   = num_cont;
            end
         end
         EMPATE: begin
`ifdef ALTERNANCIA_EN
            letra_next = SEG_J;
            num_next   = fase_next ? SEG_1 : SEG_2;
`else
            if (fase_next) begin
               letra_next = SEG_TRACO;
               num_next   = SEG_TRACO;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_reg      <= FIXO;
         jogador_ant_reg <= JOG_NENHUM;
         meios_reg       <= '0;
         letra_reg       <= SEG_APAGADO;
         num_reg         <= SEG_APAGADO;
      end else begin
         estado_reg      <= estado_next;
         jogador_ant_reg <= jogador;
         meios_reg       <= meios_next;
         letra_reg       <= letra_next;
         num_reg         <= num_next;
      end
   end

   assign display_letra = letra_reg;
   assign display_num   = num_reg;
   assign fase          = fase_cont;

endmodule

// File: tb/tb_display_vez_jogador.sv
// ---------------------------------------------------------------------------
// tb_display_vez_jogador
// Directed scenarios followed by randomized modo/jogador/reset traffic.
// The reference model tracks the displayed mode and the time elapsed since
// entering it; outputs are derived from that elapsed time.
// ---------------------------------------------------------------------------
module tb_display_vez_jogador;

   localparam int MP = 4;
   localparam int NP = 2;

   localparam logic [6:0] S_J   = 7'b1100001;
   localparam logic [6:0] S_1   = 7'b1111001;
   localparam logic [6:0] S_2   = 7'b0100100;
   localparam logic [6:0] S_E   = 7'b0000110;
   localparam logic [6:0] S_D   = 7'b0111111;
   localparam logic [6:0] S_OFF = 7'b1111111;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] jogador = 2'b00;
   logic [1:0] modo = 2'b00;
   logic [6:0] display_letra, display_num;
   logic       fase;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: 0 fixo, 1 destaque, 2 vitoria, 3 empate, 4 apagado
   int         m_kind = 0;
   int         m_t    = 0;
   logic [1:0] m_prev = 2'b00;
   logic [6:0] exp_l  = S_OFF;
   logic [6:0] exp_n  = S_OFF;
   logic       exp_f  = 1'b1;
   bit         chk_en = 1'b0;

   display_vez_jogador #(
      .MEIO_PERIODO (MP),
      .N_PISCAS     (NP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .jogador       (jogador),
      .modo          (modo),
      .display_letra (display_letra),
      .display_num   (display_num),
      .fase          (fase)
   );

   always #5 clock = ~clock;

   task automatic model_step();
      int  nk;
      bit  qual;
      bit  lit;
      logic [6:0] cl, cn;
      if (!reset) begin
         m_kind = 0; m_t = 0; m_prev = 2'b00;
         exp_l = S_OFF; exp_n = S_OFF; exp_f = 1'b1;
         return;
      end
      qual = (jogador != m_prev) && (jogador == 2'b01 || jogador == 2'b10);
      case (modo)
         2'b01: nk = 2;
         2'b10: nk = 3;
         2'b11: nk = 4;
         default: nk = ((m_kind == 0 || m_kind == 1) && qual) ? 1 :
                       (m_kind == 1) ? 1 : 0;
      endcase
      if (nk != m_kind || (nk == 1 && qual && modo == 2'b00)) m_t = 0;
      else m_t = m_t + 1;
      if (nk == 1 && m_t == 2 * NP * MP) begin
         nk = 0;
         m_t = 0;
      end
      m_kind = nk;
      m_prev = jogador;
      lit = (m_kind >= 1 && m_kind <= 3) ? ((m_t / MP) % 2 == 0) : 1'b1;
      exp_f = lit;
      case (jogador)
         2'b01:   begin cl = S_J; cn = S_1; end
         2'b10:   begin cl = S_J; cn = S_2; end
         2'b11:   begin cl = S_D; cn = S_E; end
         default: begin cl = S_D; cn = S_D; end
      endcase
      case (m_kind)
         0: begin exp_l = cl; exp_n = cn; end
         1, 2: begin exp_l = lit ? cl : S_OFF; exp_n = lit ? cn : S_OFF; end
         3: begin
`ifdef ALTERNANCIA_EN
            exp_l = S_J; exp_n = lit ? S_1 : S_2;
`else
            exp_l = lit ? S_D : S_OFF; exp_n = lit ? S_D : S_OFF;
`endif
         end
         default: begin exp_l = S_OFF; exp_n = S_OFF; end
      endcase
   endtask

   // Advance one clock: sample inputs at the edge in the model, return at
   // the following falling edge where outputs are checked.
   task automatic step();
      @(posedge clock);
      model_step();
      chk_en = 1'b1;
      @(negedge clock);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic verifica(input string nome, input logic [6:0] atual, input logic [6:0] esperado);
      compared++;
      if (atual !== esperado) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", nome, atual, esperado);
      end
   endtask

   // Continuous comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         verifica("model_letra", display_letra, exp_l);
         verifica("model_num", display_num, exp_n);
         verifica("model_fase", {6'b0, fase}, {6'b0, exp_f});
      end
   end

   initial begin
      int nrand;
      @(negedge clock);

      $display("txn reset: modo=00 jogador=00 reset low 3 cycles");
      reset = 1'b0; modo = 2'b00; jogador = 2'b00;
      step();
      verifica("reset_letra", display_letra, S_OFF);
      verifica("reset_num", display_num, S_OFF);
      verifica("reset_fase", {6'b0, fase}, 7'd1);
      steps(2);

      $display("txn release: dash/dash steady");
      reset = 1'b1;
      step();
      verifica("release_letra", display_letra, S_D);
      verifica("release_num", display_num, S_D);
      steps(3);

      $display("txn highlight: jogador 00->01");
      jogador = 2'b01;
      step();
      verifica("dest_lit_letra", display_letra, S_J);
      verifica("dest_lit_num", display_num, S_1);
      steps(4);
      verifica("dest_off_num", display_num, S_OFF);
      verifica("dest_off_fase", {6'b0, fase}, 7'd0);
      steps(11);
      verifica("dest_last_off", display_letra, S_OFF);
      step();
      verifica("dest_end_num", display_num, S_1);
      verifica("dest_end_fase", {6'b0, fase}, 7'd1);
      steps(6);
      verifica("fixo_steady", display_num, S_1);

      $display("txn restart: jogador 01->10 then 10->01 mid-highlight");
      jogador = 2'b10;
      step();
      steps(5);
      verifica("mid_dest_off", display_num, S_OFF);
      jogador = 2'b01;
      step();
      verifica("restart_num", display_num, S_1);
      verifica("restart_fase", {6'b0, fase}, 7'd1);
      steps(18);

      $display("txn vitoria: modo 01 jogador 10");
      modo = 2'b01; jogador = 2'b10;
      steps(20);
      $display("txn normal after vitoria: modo 00");
      modo = 2'b00;
      step();
      verifica("post_vit_num", display_num, S_2);
      steps(6);
      verifica("post_vit_nohl", display_num, S_2);

      $display("txn empate: modo 10");
      modo = 2'b10;
      steps(12);

      $display("txn apagado mid-blink, then reset pulse in vitoria");
      modo = 2'b01;
      steps(6);
      modo = 2'b11;
      step();
      verifica("apag_letra", display_letra, S_OFF);
      verifica("apag_fase", {6'b0, fase}, 7'd1);
      modo = 2'b01;
      steps(5);
      reset = 1'b0;
      step();
      verifica("midreset_num", display_num, S_OFF);
      verifica("midreset_fase", {6'b0, fase}, 7'd1);
      reset = 1'b1; modo = 2'b00;
      step();
      verifica("postreset_letra", display_letra, S_J);
      steps(3);

      $display("txn random traffic: 3000 cycles");
      nrand = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            modo = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            nrand++;
         end
         if ($urandom_range(0, 11) == 0) begin
            jogador = 2'($urandom_range(0, 3));
            nrand++;
         end
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         step();
      end
      $display("txn random done: %0d input changes", nrand);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
